// File: rtl/dsi_read_responder_pkg.sv
// Shared data-type codes, FSM states and response-type selection for the
// DSI peripheral read responder.
package dsi_rsp_pkg;

    localparam logic [5:0] DT_ACK_ERR    = 6'h02;
    localparam logic [5:0] DT_DCS_READ   = 6'h06;
    localparam logic [5:0] DT_GEN_SHORT1 = 6'h11;
    localparam logic [5:0] DT_GEN_SHORT2 = 6'h12;
    localparam logic [5:0] DT_GEN_READ1  = 6'h14;
    localparam logic [5:0] DT_GEN_LONG   = 6'h1A;
    localparam logic [5:0] DT_DCS_LONG   = 6'h1C;
    localparam logic [5:0] DT_DCS_SHORT1 = 6'h21;
    localparam logic [5:0] DT_DCS_SHORT2 = 6'h22;
    localparam logic [5:0] DT_GEN_READ2  = 6'h24;
    localparam logic [5:0] DT_SET_MRPS   = 6'h37;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_REQ   = 2'd2,
        ST_DATA  = 2'd3
    } rsp_state_e;

    function automatic logic [5:0] sel_dt(input logic is_dcs, input logic [7:0] n, input logic hit);
        logic [5:0] dt;
        if (!hit) begin
            dt = DT_ACK_ERR;
        end else if (n == 8'd1) begin
            dt = is_dcs ? DT_DCS_SHORT1 : DT_GEN_SHORT1;
        end else if (n == 8'd2) begin
            dt = is_dcs ? DT_DCS_SHORT2 : DT_GEN_SHORT2;
        end else begin
            dt = is_dcs ? DT_DCS_LONG : DT_GEN_LONG;
        end
        return dt;
    endfunction

endpackage

// File: rtl/dsi_read_responder_if.sv
// Periph-side RX command / TX header / TX payload bundle between the MIPI
// link layer (master) and the read responder (slave).
interface dsi_read_responder_if;
    logic [23:0] rx_cmd;
    logic        rx_cmd_valid;
    logic        dphy_direction;
    logic        tx_payload_en;
    logic        tx_payload_en_last;
    logic        tx_cmd_ack;
    logic        tx_cmd_req;
    logic [1:0]  tx_cmd_vc;
    logic [5:0]  tx_cmd_data_type;
    logic [15:0] tx_cmd_byte_count;
    logic [31:0] tx_payload;

    modport slave (
        input  rx_cmd, rx_cmd_valid, dphy_direction, tx_payload_en, tx_payload_en_last, tx_cmd_ack,
        output tx_cmd_req, tx_cmd_vc, tx_cmd_data_type, tx_cmd_byte_count, tx_payload
    );

    modport master (
        output rx_cmd, rx_cmd_valid, dphy_direction, tx_payload_en, tx_payload_en_last, tx_cmd_ack,
        input  tx_cmd_req, tx_cmd_vc, tx_cmd_data_type, tx_cmd_byte_count, tx_payload
    );
endinterface

// File: rtl/dsi_read_responder_table.sv
// Runtime-loadable register table: NUM_REGS entries of {valid, addr, len, data}
// with a combinational lowest-index-wins address match.
module dsi_rsp_table #(
    parameter int NUM_REGS  = 8,
    parameter int MAX_BYTES = 16,
    parameter int IDX_W     = 3
) (
    input  logic                   clk_periph,
    input  logic                   rstn,
    input  logic                   cfg_we_i,
    input  logic [IDX_W-1:0]       cfg_idx_i,
    input  logic [7:0]             cfg_addr_i,
    input  logic [7:0]             cfg_len_i,
    input  logic [MAX_BYTES*8-1:0] cfg_data_i,
    input  logic [7:0]             lookup_addr_i,
    output logic                   hit_o,
    output logic [7:0]             hit_len_o,
    output logic [MAX_BYTES*8-1:0] hit_data_o
);

    logic                   valid_q [NUM_REGS];
    logic [7:0]             addr_q  [NUM_REGS];
    logic [7:0]             len_q   [NUM_REGS];
    logic [MAX_BYTES*8-1:0] data_q  [NUM_REGS];

    // Entry storage; an out-of-range index writes nothing
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= 8'h00;
                len_q[i]   <= 8'h00;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cfg_we_i && (int'(cfg_idx_i) == i)) begin
                    valid_q[i] <= 1'b1;
                    addr_q[i]  <= cfg_addr_i;
                    len_q[i]   <= cfg_len_i;
                    data_q[i]  <= cfg_data_i;
                end else begin
                    valid_q[i] <= valid_q[i];
                    addr_q[i]  <= addr_q[i];
                    len_q[i]   <= len_q[i];
                    data_q[i]  <= data_q[i];
                end
            end
        end
    end

    // Priority match: scanning downward lets the lowest matching index win
    always_comb begin
        hit_o      = 1'b0;
        hit_len_o  = 8'h00;
        hit_data_o = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (valid_q[i] && (addr_q[i] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_len_o  = len_q[i];
                hit_data_o = data_q[i];
            end else begin
                hit_o      = hit_o;
                hit_len_o  = hit_len_o;
                hit_data_o = hit_data_o;
            end
        end
    end

endmodule

// File: rtl/dsi_read_responder.sv
// DSI peripheral read-response engine: decodes reads / set-max-return-size,
// looks the address up, and answers with a short, long or ack-and-error packet after BTA.
module dsi_read_responder
    import dsi_rsp_pkg::*;
#(
    parameter int          NUM_REGS     = 8,
    parameter int          MAX_BYTES    = 16,
    parameter logic [1:0]  VC           = 2'd0,
    parameter logic [15:0] DEFAULT_MRPS = 16'd1,
    parameter logic [15:0] ERR_CODE     = 16'h0200,
    localparam int         IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                   clk_periph,
    input  logic                   rstn,
    dsi_read_responder_if.slave    bus,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [7:0]             cfg_addr,
    input  logic [7:0]             cfg_len,
    input  logic [MAX_BYTES*8-1:0] cfg_data,
    output logic                   busy,
    output logic                   err_drop
);

    localparam int NW = MAX_BYTES / 4;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;

    logic [23:0] rx_cmd_q;
    logic        rx_valid_q, dir_q, dir_dly_q, pen_q, plast_q;

    rsp_state_e             state_q, state_d;
    logic [15:0]            mrps_q, mrps_d;
    logic [5:0]             rsp_dt_q, rsp_dt_d;
    logic [15:0]            rsp_bc_q, rsp_bc_d;
    logic                   rsp_long_q, rsp_long_d;
    logic [MAX_BYTES*8-1:0] rsp_data_q, rsp_data_d;
    logic [WW-1:0]          widx_q, widx_d;
    logic                   last_pend_q, last_pend_d;
    logic                   req_q, req_d;
    logic [1:0]             vc_q;
    logic [5:0]             dt_out_q, dt_out_d;
    logic [15:0]            bc_out_q, bc_out_d;
    logic [31:0]            pay_q, pay_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic [5:0]             dt_s;
    logic                   is_dcs_s, is_read_s, is_mrps_s, bta_s;
    logic                   hit_s, new_long_s;
    logic [7:0]             len_s, n_s;
    logic [MAX_BYTES*8-1:0] data_s, masked_s;
    logic [5:0]             new_dt_s;
    logic [15:0]            new_bc_s;
    logic [31:0]            word_s;
    logic                   unused_vc_s;

    assign dt_s        = rx_cmd_q[5:0];
    assign unused_vc_s = ^rx_cmd_q[7:6];
    assign is_dcs_s    = (dt_s == DT_DCS_READ);
    assign is_read_s   = rx_valid_q && (is_dcs_s || (dt_s == DT_GEN_READ1) || (dt_s == DT_GEN_READ2));
    assign is_mrps_s   = rx_valid_q && (dt_s == DT_SET_MRPS);
    assign bta_s       = dir_dly_q & ~dir_q;

    dsi_rsp_table #(
        .NUM_REGS  (NUM_REGS),
        .MAX_BYTES (MAX_BYTES),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk_periph    (clk_periph),
        .rstn          (rstn),
        .cfg_we_i      (cfg_we),
        .cfg_idx_i     (cfg_idx),
        .cfg_addr_i    (cfg_addr),
        .cfg_len_i     (cfg_len),
        .cfg_data_i    (cfg_data),
        .lookup_addr_i (rx_cmd_q[15:8]),
        .hit_o         (hit_s),
        .hit_len_o     (len_s),
        .hit_data_o    (data_s)
    );

    assign n_s        = ({8'h00, len_s} < mrps_q) ? len_s : mrps_q[7:0];
    assign new_dt_s   = sel_dt(is_dcs_s, n_s, hit_s);
    assign new_long_s = hit_s && (n_s > 8'd2);

    // Response fields computed at decode; bytes beyond n are cleared here once
    always_comb begin
        masked_s = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (b < int'(n_s)) begin
                masked_s[b*8 +: 8] = data_s[b*8 +: 8];
            end else begin
                masked_s[b*8 +: 8] = 8'h00;
            end
        end
        if (!hit_s) begin
            new_bc_s = ERR_CODE;
        end else if (n_s == 8'd1) begin
            new_bc_s = {8'h00, data_s[7:0]};
        end else if (n_s == 8'd2) begin
            new_bc_s = {data_s[15:8], data_s[7:0]};
        end else begin
            new_bc_s = {8'h00, n_s};
        end
    end

    // Next-state logic, response latch, mrps update and payload word index
    always_comb begin
        state_d     = state_q;
        mrps_d      = mrps_q;
        rsp_dt_d    = rsp_dt_q;
        rsp_bc_d    = rsp_bc_q;
        rsp_long_d  = rsp_long_q;
        rsp_data_d  = rsp_data_q;
        widx_d      = widx_q;
        last_pend_d = last_pend_q;
        err_d       = 1'b0;

        if (is_mrps_s) begin
            mrps_d = (rx_cmd_q[23:8] == 16'h0000) ? 16'h0001 : rx_cmd_q[23:8];
        end else begin
            mrps_d = mrps_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (is_read_s) begin
                    rsp_dt_d   = new_dt_s;
                    rsp_bc_d   = new_bc_s;
                    rsp_long_d = new_long_s;
                    rsp_data_d = masked_s;
                    state_d    = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (is_read_s) begin
                    rsp_dt_d   = new_dt_s;
                    rsp_bc_d   = new_bc_s;
                    rsp_long_d = new_long_s;
                    rsp_data_d = masked_s;
                    err_d      = 1'b1;
                end else begin
                    err_d = 1'b0;
                end
                if (bta_s) begin
                    state_d     = ST_REQ;
                    widx_d      = '0;
                    last_pend_d = 1'b0;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_REQ: begin
                err_d = is_read_s;
                if (bus.tx_cmd_ack) begin
                    state_d     = rsp_long_q ? ST_DATA : ST_IDLE;
                    last_pend_d = plast_q;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DATA: begin
                err_d = is_read_s;
                if (pen_q && (widx_q != WW'(NW - 1))) begin
                    widx_d = widx_q + 1'b1;
                end else begin
                    widx_d = widx_q;
                end
                if (plast_q || last_pend_q) begin
                    state_d     = ST_IDLE;
                    last_pend_d = 1'b0;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Payload word select from the (next) latched response
    always_comb begin
        word_s = 32'h0000_0000;
        for (int w = 0; w < NW; w++) begin
            word_s = (int'(widx_d) == w) ? rsp_data_d[w*32 +: 32] : word_s;
        end
    end

    // Registered output values derived from the next state
    always_comb begin
        req_d    = (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
        dt_out_d = (state_d == ST_REQ) ? rsp_dt_d : 6'h00;
        bc_out_d = (state_d == ST_REQ) ? rsp_bc_d : 16'h0000;
        if (((state_d == ST_REQ) || (state_d == ST_DATA)) && rsp_long_d) begin
            pay_d = word_s;
        end else begin
            pay_d = 32'h0000_0000;
        end
    end

    // Input staging and all state/output registers
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            rx_cmd_q    <= 24'h000000;
            rx_valid_q  <= 1'b0;
            dir_q       <= 1'b0;
            dir_dly_q   <= 1'b0;
            pen_q       <= 1'b0;
            plast_q     <= 1'b0;
            state_q     <= ST_IDLE;
            mrps_q      <= DEFAULT_MRPS;
            rsp_dt_q    <= 6'h00;
            rsp_bc_q    <= 16'h0000;
            rsp_long_q  <= 1'b0;
            rsp_data_q  <= '0;
            widx_q      <= '0;
            last_pend_q <= 1'b0;
            req_q       <= 1'b0;
            vc_q        <= VC;
            dt_out_q    <= 6'h00;
            bc_out_q    <= 16'h0000;
            pay_q       <= 32'h0000_0000;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rx_cmd_q    <= bus.rx_cmd;
            rx_valid_q  <= bus.rx_cmd_valid;
            dir_q       <= bus.dphy_direction;
            dir_dly_q   <= dir_q;
            pen_q       <= bus.tx_payload_en;
            plast_q     <= bus.tx_payload_en_last;
            state_q     <= state_d;
            mrps_q      <= mrps_d;
            rsp_dt_q    <= rsp_dt_d;
            rsp_bc_q    <= rsp_bc_d;
            rsp_long_q  <= rsp_long_d;
            rsp_data_q  <= rsp_data_d;
            widx_q      <= widx_d;
            last_pend_q <= last_pend_d;
            req_q       <= req_d;
            vc_q        <= VC;
            dt_out_q    <= dt_out_d;
            bc_out_q    <= bc_out_d;
            pay_q       <= pay_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.tx_cmd_req        = req_q;
    assign bus.tx_cmd_vc         = vc_q;
    assign bus.tx_cmd_data_type  = dt_out_q;
    assign bus.tx_cmd_byte_count = bc_out_q;
    assign bus.tx_payload        = pay_q;
    assign busy                  = busy_q;
    assign err_drop              = err_q;

endmodule
